ctrl_seq_checker: RTL

//  Passive monitor on the multicycle Controller's outputs. Each cycle it compares the control vector

---
 rtl/ctrl_seq_checker_if.sv | 32 +++
 rtl/ctrl_seq_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq_checker_if
// Brief    : Multicycle Controller control vector and opcode, as seen by the checker
// Revision : 1.0  initial release
// ============================================================================
interface ctrl_seq_checker_if;
   logic [5:0] Op;
   logic       PCWrite;
   logic       lorD;
   logic       MemWrite;
   logic       MemtoReg;
   logic       IRWrite;
   logic [1:0] PCSrc;
   logic [1:0] ALUOp;
   logic [1:0] ALUSrcB;
   logic       ALUSrcA;
   logic       RegWrite;
   logic       RegDst;
   logic       Branch;

   modport master (
      output Op, PCWrite, lorD, MemWrite, MemtoReg, IRWrite, PCSrc,
             ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, Branch
   );

   modport slave (
      input  Op, PCWrite, lorD, MemWrite, MemtoReg, IRWrite, PCSrc,
             ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, Branch
   );
endinterface
`default_nettype wire

// File: rtl/ctrl_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq_checker
// Brief    : Passive lock-step checker of the MIPS multicycle Controller FSM
// Revision : 1.0  initial release
// ============================================================================
module ctrl_seq_checker #(
   parameter int CNT_W = 16
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   ctrl_seq_checker_if.slave     ctl,
   output logic                  locked,
   output logic [3:0]            state_obs,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic [CNT_W-1:0]      instr_cnt
);

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2,  ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,  ST_MEMWR  = 4'd5,  ST_EXEC   = 4'd6,  ST_ALUWB  = 4'd7,
      ST_BEQ    = 4'd8,  ST_ADDIEX = 4'd9,  ST_ADDIWB = 4'd10, ST_JUMP   = 4'd11,
      ST_NONE   = 4'd15
   } ctrl_st_t;

   typedef enum logic {
      CHK_UNLOCKED = 1'b0,
      CHK_LOCKED   = 1'b1
   } chk_st_t;

   typedef struct packed {
      logic       pcwrite;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic       branch;
      logic       lord;
      logic       memtoreg;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic [1:0] alusrcb;
      logic       alusrca;
      logic       regdst;
   } cv_t;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_j     = 6'b000010;
   localparam logic [6:0] c_timeout  = 7'd64;

   // Strobe order in the match table: PCWrite MemWrite IRWrite RegWrite Branch
   function automatic logic f_match(input cv_t cv, input ctrl_st_t st);
      logic [4:0] strb;
      strb    = {cv.pcwrite, cv.memwrite, cv.irwrite, cv.regwrite, cv.branch};
      f_match = 1'b0;
      case (st)
         ST_FETCH:  f_match = (strb == 5'b10100) && !cv.lord && !cv.alusrca &&
                              (cv.alusrcb == 2'b01) && (cv.aluop == 2'b00) && (cv.pcsrc == 2'b00);
         ST_DECODE: f_match = (strb == 5'b00000) && !cv.alusrca &&
                              (cv.alusrcb == 2'b11) && (cv.aluop == 2'b00);
         ST_MEMADR,
         ST_ADDIEX: f_match = (strb == 5'b00000) && cv.alusrca &&
                              (cv.alusrcb == 2'b10) && (cv.aluop == 2'b00);
         ST_MEMRD:  f_match = (strb == 5'b00000) && cv.lord;
         ST_MEMWR:  f_match = (strb == 5'b01000) && cv.lord;
         ST_MEMWB:  f_match = (strb == 5'b00010) && !cv.regdst && cv.memtoreg;
         ST_ALUWB:  f_match = (strb == 5'b00010) && cv.regdst && !cv.memtoreg;
         ST_ADDIWB: f_match = (strb == 5'b00010) && !cv.regdst && !cv.memtoreg;
         ST_EXEC:   f_match = (strb == 5'b00000) && cv.alusrca &&
                              (cv.alusrcb == 2'b00) && (cv.aluop == 2'b10);
         ST_BEQ:    f_match = (strb == 5'b00001) && cv.alusrca && (cv.alusrcb == 2'b00) &&
                              (cv.aluop == 2'b01) && (cv.pcsrc == 2'b01);
         ST_JUMP:   f_match = (strb == 5'b10000) && (cv.pcsrc == 2'b10);
         default:   f_match = 1'b0;
      endcase
   endfunction

   function automatic logic f_op_legal(input logic [5:0] op);
      case (op)
         c_op_rtype, c_op_lw, c_op_sw, c_op_beq, c_op_addi, c_op_j: f_op_legal = 1'b1;
         default:                                                  f_op_legal = 1'b0;
      endcase
   endfunction

   // DECODE branches on the live opcode; MEMADR on the one captured in DECODE
   function automatic ctrl_st_t f_next(input ctrl_st_t st, input logic [5:0] op_live,
                                       input logic [5:0] op_reg);
      f_next = ST_FETCH;
      case (st)
         ST_FETCH:  f_next = ST_DECODE;
         ST_DECODE: begin
            case (op_live)
               c_op_lw, c_op_sw: f_next = ST_MEMADR;
               c_op_rtype:       f_next = ST_EXEC;
               c_op_beq:         f_next = ST_BEQ;
               c_op_addi:        f_next = ST_ADDIEX;
               c_op_j:           f_next = ST_JUMP;
               default:          f_next = ST_FETCH;
            endcase
         end
         ST_MEMADR: f_next = (op_reg == c_op_lw) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:  f_next = ST_MEMWB;
         ST_EXEC:   f_next = ST_ALUWB;
         ST_ADDIEX: f_next = ST_ADDIWB;
         default:   f_next = ST_FETCH;
      endcase
   endfunction

   function automatic logic f_terminal(input ctrl_st_t st);
      case (st)
         ST_MEMWB, ST_MEMWR, ST_ALUWB, ST_BEQ, ST_ADDIWB, ST_JUMP: f_terminal = 1'b1;
         default:                                                  f_terminal = 1'b0;
      endcase
   endfunction

   cv_t              w_cv;
   chk_st_t          r_fsm, w_fsm_nxt;
   ctrl_st_t         r_exp, w_exp_nxt;
   ctrl_st_t         w_obs;
   logic [5:0]       r_op;
   logic [6:0]       r_to, w_to_nxt;
   logic [1:0]       r_err_code, w_code;
   logic [CNT_W-1:0] r_cnt;
   logic             w_locked, w_err, w_retire, w_cap_op;

   assign w_cv = '{pcwrite:  ctl.PCWrite,  memwrite: ctl.MemWrite, irwrite: ctl.IRWrite,
                   regwrite: ctl.RegWrite, branch:   ctl.Branch,   lord:    ctl.lorD,
                   memtoreg: ctl.MemtoReg, pcsrc:    ctl.PCSrc,    aluop:   ctl.ALUOp,
                   alusrcb:  ctl.ALUSrcB,  alusrca:  ctl.ALUSrcA,  regdst:  ctl.RegDst};

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_fsm      <= CHK_UNLOCKED;
         r_exp      <= ST_FETCH;
         r_op       <= 6'd0;
         r_to       <= 7'd0;
         r_err_code <= 2'b00;
         r_cnt      <= '0;
      end else begin
         r_fsm <= w_fsm_nxt;
         r_exp <= w_exp_nxt;
         r_to  <= w_to_nxt;
         if (w_cap_op) r_op       <= ctl.Op;
         if (w_err)    r_err_code <= w_code;
         if (w_retire) r_cnt      <= r_cnt + 1'b1;
      end
   end

   // Everything is gated by Rst_n so a reset cycle never reports a lock or an error
   always_comb begin
      w_fsm_nxt = r_fsm;
      w_exp_nxt = r_exp;
      w_to_nxt  = r_to;
      w_obs     = ST_NONE;
      w_locked  = 1'b0;
      w_err     = 1'b0;
      w_code    = 2'b00;
      w_retire  = 1'b0;
      w_cap_op  = 1'b0;
      if (Rst_n) begin
         case (r_fsm)
            CHK_UNLOCKED: begin
               if (f_match(w_cv, ST_FETCH)) begin
                  w_locked  = 1'b1;
                  w_obs     = ST_FETCH;
                  w_fsm_nxt = CHK_LOCKED;
                  w_exp_nxt = ST_DECODE;
                  w_to_nxt  = 7'd0;
               end else if (r_to == c_timeout) begin
                  w_err    = 1'b1;
                  w_code   = 2'b11;
                  w_to_nxt = 7'd0;
               end else begin
                  w_to_nxt = r_to + 7'd1;
               end
            end
            CHK_LOCKED: begin
               w_locked = 1'b1;
               w_to_nxt = 7'd0;
               if (!f_match(w_cv, r_exp)) begin
                  w_err     = 1'b1;
                  w_code    = 2'b01;
                  w_fsm_nxt = CHK_UNLOCKED;
                  w_exp_nxt = ST_FETCH;
               end else if ((r_exp == ST_DECODE) && !f_op_legal(ctl.Op)) begin
                  w_err     = 1'b1;
                  w_code    = 2'b10;
                  w_fsm_nxt = CHK_UNLOCKED;
                  w_exp_nxt = ST_FETCH;
               end else begin
                  w_obs     = r_exp;
                  w_exp_nxt = f_next(r_exp, ctl.Op, r_op);
                  w_retire  = f_terminal(r_exp);
                  w_cap_op  = (r_exp == ST_DECODE);
               end
            end
         endcase
      end
   end

   assign locked    = w_locked;
   assign state_obs = w_obs;
   assign err       = w_err;
   assign err_code  = w_err ? w_code : r_err_code;
   assign instr_cnt = r_cnt;

endmodule
`default_nettype wire
